// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with ALU function decode
// Optional bne support is compiled in when MIPS_MC_BNE_EN is defined.
module mips_mc_controller #(
  parameter int FW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  input  logic          zero,
  output logic          pcen,
  output logic          memwrite,
  output logic          irwrite,
  output logic          regwrite,
  output logic          iord,
  output logic          alusrca,
  output logic [1:0]    alusrcb,
  output logic          regdst,
  output logic          memtoreg,
  output logic [1:0]    pcsrc,
  output logic [FW-1:0] alucontrol
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MIPS_MC_BNE_EN
    BNE     = 4'd12,
`endif
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
`ifdef MIPS_MC_BNE_EN
    logic       branchne;
`endif
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  state_t state;
  ctl_t   ctl;

  function automatic state_t next_of(input state_t s, input logic [5:0] o);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE: begin
        case (o)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXECUTE;
          OP_BEQ:       n = BRANCH;
          OP_ADDI:      n = ADDIEX;
          OP_J:         n = JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       n = BNE;
`endif
          default:      n = FETCH;
        endcase
      end
      MEMADR:  n = (o == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = MEMWB;
      EXECUTE: n = ALUWB;
      ADDIEX:  n = ADDIWB;
      default: n = FETCH;  // writeback/branch/jump ends and any corrupt encoding
    endcase
    return n;
  endfunction

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
`ifdef MIPS_MC_BNE_EN
      BNE: begin
        c.alusrca  = 1'b1;
        c.aluop    = 2'b01;
        c.pcsrc    = 2'b01;
        c.branchne = 1'b1;
      end
`endif
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= ctl_of(FETCH);
    end else begin
      state <= next_of(state, op);
      ctl   <= ctl_of(next_of(state, op));
    end
  end

  logic bne_take;
`ifdef MIPS_MC_BNE_EN
  assign bne_take = ctl.branchne & ~zero;
`else
  assign bne_take = 1'b0;
`endif

  // Reset gates the write strobes so the held FETCH values cannot fire early.
  assign pcen     = ~reset & (ctl.pcwrite | (ctl.branch & zero) | bne_take);
  assign memwrite = ~reset & ctl.memwrite;
  assign irwrite  = ~reset & ctl.irwrite;
  assign regwrite = ~reset & ctl.regwrite;
  assign iord     = ctl.iord;
  assign alusrca  = ctl.alusrca;
  assign alusrcb  = ctl.alusrcb;
  assign regdst   = ctl.regdst;
  assign memtoreg = ctl.memtoreg;
  assign pcsrc    = ctl.pcsrc;

  always_comb begin
    alucontrol = 3'b010;
    case (ctl.aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed scoreboard bench for mips_mc_controller
// Expects the bne state only when MIPS_MC_BNE_EN is defined.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;

  logic [14:0] sb[$];
  string       tags[$];
  logic [14:0] obs;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JUMP = 11, S_BNE = 12, S_RST = 13;

  mips_mc_controller #(.FW(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  assign obs = {pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
                regdst, memtoreg, pcsrc, alucontrol};

  function automatic logic [14:0] expv(input int s, input logic z, input logic [5:0] fn);
    logic p, mw, ir, rw, io, asa, rd, mtr;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {p, mw, ir, rw, io, asa, rd, mtr} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (s)
      S_FETCH:  begin p = 1; ir = 1; asb = 2'b01; end
      S_RST:    asb = 2'b01;
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  io = 1;
      S_MEMWB:  begin mtr = 1; rw = 1; end
      S_MEMWR:  begin io = 1; mw = 1; end
      S_EXEC: begin
        asa = 1;
        case (fn)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      S_ALUWB:  begin rd = 1; rw = 1; end
      S_BRANCH: begin asa = 1; pcs = 2'b01; alu = 3'b110; p = z; end
      S_BNE:    begin asa = 1; pcs = 2'b01; alu = 3'b110; p = ~z; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin pcs = 2'b10; p = 1; end
      default:  ;
    endcase
    return {p, mw, ir, rw, io, asa, asb, rd, mtr, pcs, alu};
  endfunction

  task automatic push(input int s, input string tag);
    sb.push_back(expv(s, zero, funct));
    tags.push_back(tag);
  endtask

  task automatic check_now();
    logic [14:0] e;
    string t;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %h expected an entry", obs);
    end else begin
      e = sb.pop_front();
      t = tags.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] rfn [5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    @(posedge clk); #1;
    push(S_RST, "reset_hold");
    drain(1);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      op = 6'b000000;
      funct = (k < 5) ? rfn[k] : 6'b111111;
      push(S_FETCH, "r_fetch"); push(S_DECODE, "r_decode");
      push(S_EXEC, "r_execute"); push(S_ALUWB, "r_aluwb");
      drain(4);
    end

    op = 6'b100011; funct = 6'b0;
    push(S_FETCH, "lw_fetch"); push(S_DECODE, "lw_decode"); push(S_MEMADR, "lw_memadr");
    push(S_MEMRD, "lw_memrd"); push(S_MEMWB, "lw_memwb");
    drain(5);
    op = 6'b101011;
    push(S_FETCH, "sw_fetch"); push(S_DECODE, "sw_decode"); push(S_MEMADR, "sw_memadr");
    push(S_MEMWR, "sw_memwr");
    drain(4);

    op = 6'b000100; zero = 1'b1;
    push(S_FETCH, "beq_t_fetch"); push(S_DECODE, "beq_t_decode"); push(S_BRANCH, "beq_taken");
    drain(3);
    zero = 1'b0;
    push(S_FETCH, "beq_n_fetch"); push(S_DECODE, "beq_n_decode"); push(S_BRANCH, "beq_not_taken");
    drain(3);

    op = 6'b000010;
    push(S_FETCH, "j_fetch"); push(S_DECODE, "j_decode"); push(S_JUMP, "j_jump");
    drain(3);
    op = 6'b001000;
    push(S_FETCH, "addi_fetch"); push(S_DECODE, "addi_decode");
    push(S_ADDIEX, "addi_ex"); push(S_ADDIWB, "addi_wb");
    drain(4);
    op = 6'b111111;
    push(S_FETCH, "ill_fetch"); push(S_DECODE, "ill_decode");
    drain(2);

    op = 6'b000101; zero = 1'b0;
    push(S_FETCH, "bne_fetch"); push(S_DECODE, "bne_decode");
`ifdef MIPS_MC_BNE_EN
    push(S_BNE, "bne_taken");
    drain(3);
    zero = 1'b1;
    push(S_FETCH, "bne_n_fetch"); push(S_DECODE, "bne_n_decode"); push(S_BNE, "bne_not_taken");
    drain(3);
`else
    drain(2);
`endif
    zero = 1'b0;

    op = 6'b100011;
    push(S_FETCH, "rst_lw_fetch"); push(S_DECODE, "rst_lw_decode"); push(S_MEMADR, "rst_lw_memadr");
    drain(3);
    push(S_MEMRD, "rst_lw_memrd");
    @(negedge clk);
    check_now();
    #1 reset = 1'b1;
    #1;
    push(S_RST, "reset_async_mid_memrd");
    check_now();
    @(posedge clk); #1;
    push(S_RST, "reset_held_over_edge");
    check_now();
    reset = 1'b0;
    push(S_FETCH, "post_reset_fetch"); push(S_DECODE, "post_reset_decode");
    push(S_MEMADR, "post_reset_memadr"); push(S_MEMRD, "post_reset_memrd");
    push(S_MEMWB, "post_reset_memwb");
    drain(5);

    push(S_FETCH, "final_fetch");
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle MIPS control unit: the control end of the ALU interface.
- Decodes the latched instruction's op/funct and sequences FETCH→DECODE→execute→writeback as a Moore FSM.
- Drives the ALU 3-bit F code (alucontrol) and datapath strobes, and consumes the ALU zero flag for branch resolution.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- FW, 3, width of the ALU function code (fixed encoding below; not meant to change).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag, same cycle.
- pcen  output  1  PC register enable.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- regwrite  output  1  register file write.
- iord  output  1  0 = PC addresses memory, 1 = ALUOut.
- alusrca  output  1  0 = PC, 1 = rs data.
- alusrcb  output  2  00 = rt, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- regdst  output  1  0 = rt, 1 = rd.
- memtoreg  output  1  0 = ALUOut, 1 = Data.
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  output  FW  ALU F: 010 add, 110 sub, 000 and, 001 or, 111 slt.

Behaviour:
- Reset is asynchronous and active-high: state→FETCH immediately.
- While reset is high, pcen, memwrite, irwrite and regwrite are forced 0. All other outputs take their FETCH values.
- Reset mid-instruction abandons it. The first FETCH strobes occur in the first cycle after reset deasserts.
- Outputs are a decode of the state only (Moore); pcen is the exception. Unlisted outputs are 0; internal aluop = 00.
- State outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatches on op: 100011 lw / 101011 sw → MEMADR; 000000 R-type → EXECUTE; 000100 beq → BRANCH; 001000 addi → ADDIEX; 000010 j → JUMP; any other op → FETCH (illegal op executes as a nop).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- pcen = pcwrite | (branch & zero), combinational.
- Cycles per instruction: lw 5; R-type, sw, addi 4; beq, j 3; illegal 2.
- ALU decode:
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10 decodes funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Unknown funct → 010; regwrite still asserts in ALUWB.
  - aluop 11 is never produced.
- The state register has no unreachable lockup: any undefined encoding → FETCH on the next edge.

Optional Feature:
- Macro: MIPS_MC_BNE_EN.
- Defined: op 000101 (bne) dispatches from DECODE to state BNE. BNE has BRANCH's outputs with aluop=01, but pcen = pcwrite | (branch & zero) | (branchne & ~zero). BNE takes 3 cycles and then returns to FETCH.
- Undefined: op 000101 is illegal, DECODE→FETCH, and the branchne term is absent (tied 0).

Test Plan:
- Reset asserted mid-MEMRD of lw (op=100011) → state FETCH immediately; pcen/irwrite/memwrite/regwrite=0 while reset is high; irwrite=1, pcen=1, alucontrol=010 in the first cycle after release.
- R-type, funct=101010 (slt) → 4 cycles. EXECUTE has alucontrol=111, alusrca=1, alusrcb=00. ALUWB has regwrite=1, regdst=1. Repeat for funct 100000/100010/100100/100101 → 010/110/000/001.
- lw then sw back-to-back → lw: FETCH, DECODE, MEMADR, MEMRD(iord=1), MEMWB(memtoreg=1, regwrite=1), 5 cycles. sw: 4 cycles with memwrite=1 only in MEMWR.
- beq (op=000100) with zero=1 → pcen=1, pcsrc=01, alucontrol=110 in BRANCH. With zero=0 → pcen=0. Both take 3 cycles.
- j (op=000010) → JUMP: pcsrc=10, pcen=1, 3 cycles. Illegal op=111111 → DECODE→FETCH with no write strobe asserted, 2 cycles.
- bne (op=000101), zero=0 → with MIPS_MC_BNE_EN: pcen=1 in BNE. Without the macro: FETCH after DECODE, pcen=0.
